// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU instruction sequencer: opcodes, ALU select codes,
// FSM states and the opcode decoder used by the sequencer.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b0101;
    localparam logic [3:0] OP_OUT_W = 4'b0110;
    localparam logic [3:0] OP_OUT_R = 4'b0111;

    localparam logic [2:0] ALU_SEL_ADD  = 3'b000;
    localparam logic [2:0] ALU_SEL_SUB  = 3'b001;
    localparam logic [2:0] ALU_SEL_MUL  = 3'b100;
    localparam logic [2:0] ALU_SEL_DIV  = 3'b101;
    localparam logic [2:0] ALU_SEL_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Single-cycle ALU ops, multi-cycle ALU ops (wait for alu_done), register strobes.
    typedef enum logic [2:0] {
        KIND_ALU,
        KIND_ALU_MC,
        KIND_OUT_W,
        KIND_OUT_R,
        KIND_ILLEGAL
    } op_kind_t;

    typedef struct packed {
        op_kind_t   kind;
        logic [2:0] op_select;
        logic       sub;
    } decode_t;

    function automatic decode_t decode_opcode(input logic [3:0] opcode);
        decode_t d;
        d.kind      = KIND_ILLEGAL;
        d.op_select = ALU_SEL_NONE;
        d.sub       = 1'b0;
        case (opcode)
            OP_ADD: begin
                d.kind      = KIND_ALU;
                d.op_select = ALU_SEL_ADD;
            end
            OP_SUB: begin
                d.kind      = KIND_ALU;
                d.op_select = ALU_SEL_SUB;
                d.sub       = 1'b1;
            end
            OP_MUL: begin
                d.kind      = KIND_ALU_MC;
                d.op_select = ALU_SEL_MUL;
            end
            OP_DIV: begin
                d.kind      = KIND_ALU_MC;
                d.op_select = ALU_SEL_DIV;
            end
            OP_OUT_W: d.kind = KIND_OUT_W;
            OP_OUT_R: d.kind = KIND_OUT_R;
            default:  d.kind = KIND_ILLEGAL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of the sequencer's instruction handshake, ALU controls, output-register
// strobes and status; slave is the sequencer side, master the instruction source/datapath.
interface alu_sequencer_if #(
    parameter int CNT_W = 16
);

    logic             instr_valid;
    logic [7:0]       instr;
    logic             instr_ready;
    logic [2:0]       alu_op_select;
    logic             alu_sub;
    logic             alu_start;
    logic             alu_done;
    logic             out_write_enable;
    logic             out_read_enable;
    logic [4:0]       out_index;
    logic             busy;
    logic             illegal;
    logic             timeout;
    logic [CNT_W-1:0] retired;

    modport master (
        output instr_valid, instr, alu_done,
        input  instr_ready, alu_op_select, alu_sub, alu_start,
               out_write_enable, out_read_enable, out_index,
               busy, illegal, timeout, retired
    );

    modport slave (
        input  instr_valid, instr, alu_done,
        output instr_ready, alu_op_select, alu_sub, alu_start,
               out_write_enable, out_read_enable, out_index,
               busy, illegal, timeout, retired
    );

endinterface

// File: rtl/alu_sequencer_op_timer.sv
// WAIT-state cycle counter: cleared when a multi-cycle op launches, counts while
// waiting, and flags expiry once it has reached TIMEOUT-1.
module op_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             W    = $clog2(TIMEOUT);
    localparam logic [W-1:0]   LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count_q;

    // NOTE: flops are written with <= so each one samples pre-edge values whatever the block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + W'(1);
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer: latches one instruction, drives ALU/output-register
// controls from the registered instruction, waits on alu_done for MUL/DIV under a timeout.
module alu_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic            clk,
    input  logic            reset,
    alu_sequencer_if.slave  bus
);

    import alu_seq_pkg::*;

    state_t           state_q, state_d;
    logic [7:0]       ir_q;
    logic [CNT_W-1:0] retired_q;
    logic             timeout_q, timeout_d;

    logic    ir_load;
    logic    retire;
    logic    timer_clear;
    logic    timer_enable;
    logic    timer_expired;
    logic    alu_start;
    logic    out_we;
    logic    out_re;
    logic    illegal;
    decode_t dec;

    assign dec = decode_opcode(ir_q[7:4]);

    op_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_op_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves a latch.
        state_d      = state_q;
        ir_load      = 1'b0;
        retire       = 1'b0;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;
        timeout_d    = 1'b0;
        alu_start    = 1'b0;
        out_we       = 1'b0;
        out_re       = 1'b0;
        illegal      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    ir_load = 1'b1;
                    state_d = EXEC;
                end
            end

            EXEC: begin
                state_d = IDLE;
                case (dec.kind)
                    KIND_ALU: begin
                        alu_start = 1'b1;
                        retire    = 1'b1;
                    end
                    KIND_ALU_MC: begin
                        alu_start   = 1'b1;
                        timer_clear = 1'b1;
                        state_d     = WAIT;
                    end
                    KIND_OUT_W: begin
                        out_we = 1'b1;
                        retire = 1'b1;
                    end
                    KIND_OUT_R: begin
                        out_re = 1'b1;
                        retire = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end

            WAIT: begin
                // Completion wins over expiry when both land in the same cycle.
                if (bus.alu_done) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end else if (timer_expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_enable = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // The timeout decision depends on alu_done, so it is registered to keep outputs input-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q      <= '0;
            retired_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
            if (ir_load) begin
                ir_q <= bus.instr;
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign bus.instr_ready      = (state_q == IDLE) && !reset;
    assign bus.busy             = (state_q != IDLE);
    assign bus.alu_op_select    = (state_q != IDLE) ? dec.op_select : ALU_SEL_NONE;
    assign bus.alu_sub          = (state_q != IDLE) && dec.sub;
    assign bus.alu_start        = alu_start;
    assign bus.out_write_enable = out_we;
    assign bus.out_read_enable  = out_re;
    assign bus.out_index        = (out_we || out_re) ? {1'b0, ir_q[3:0]} : 5'd0;
    assign bus.illegal          = illegal;
    assign bus.timeout          = timeout_q;
    assign bus.retired          = retired_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle instruction sequencer for the ALU/output-register datapath. Accepts 8-bit instructions over a valid/ready handshake and decodes opcode bits [7:4]. Drives the ALU operation controls and the output-register enables, holding them stable until the operation completes. Multiply/divide completion comes from an ALU done flag, guarded by a timeout; the block also keeps a retired-instruction count.

## Interface
Parameters:
- TIMEOUT, 64, max cycles spent in WAIT for alu_done before abort (≥2)
- CNT_W, 16, width of retired-instruction counter

Ports (clock and reset are fixed: one clock; reset is asynchronous and active-high):
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr  in  8  instruction; opcode = [7:4]
- instr_ready  out  1  sequencer can accept an instruction
- alu_op_select  out  3  ALU operation select
- alu_sub  out  1  ALU subtract control
- alu_start  out  1  one-cycle ALU launch pulse
- alu_done  in  1  multi-cycle ALU op complete (MUL/DIV only)
- out_write_enable  out  1  output-register write strobe
- out_read_enable  out  1  output-register read strobe
- out_index  out  5  output-register index = {1'b0, ir[3:0]}
- busy  out  1  state ≠ IDLE
- illegal  out  1  one-cycle pulse on undefined opcode
- timeout  out  1  one-cycle pulse on WAIT abort
- retired  out  CNT_W  count of completed instructions; wraps

## Operation
- Accept: in IDLE, instr_valid && instr_ready latches instr into ir; next state EXEC. The sequencer holds one instruction at a time, with no queue.
- Opcode decode of ir[7:4]:
  - 0000 ADD: op_select 000, sub 0
  - 0001 SUB: op_select 001, sub 1
  - 0100 MUL: op_select 100
  - 0101 DIV: op_select 101
  - 0110 OUT_W
  - 0111 OUT_R
  - any other value is illegal
- EXEC, one cycle:
  - ADD/SUB: alu_start=1; retire; go to IDLE.
  - MUL/DIV: alu_start=1; clear timer; go to WAIT.
  - OUT_W: out_write_enable=1; retire; go to IDLE.
  - OUT_R: out_read_enable=1; retire; go to IDLE.
  - Illegal: illegal=1; no enables; no retire; go to IDLE.
- WAIT:
  - alu_op_select/alu_sub stay held and alu_start=0.
  - If alu_done: retire and go to IDLE.
  - Otherwise increment timer. When timer reaches TIMEOUT-1 without alu_done, pulse timeout and go to IDLE without retiring.
- alu_done is ignored outside WAIT. alu_done in the same cycle as timer==TIMEOUT-1 counts as completion, not timeout.
- alu_op_select/alu_sub are decoded from ir in EXEC and WAIT; they are 000/0 in IDLE.
- out_index is valid whenever out_write_enable or out_read_enable is high; it is 0 otherwise.
- retired increments by 1 on each retire, wrapping from 2^CNT_W-1 to 0.

## Timing
- All state registers reset asynchronously on reset=1: state=IDLE, ir=0, timer=0, retired=0.
- Outputs are decoded from registered state/ir, with no combinational path from inputs to outputs except instr_ready (state only).
- Reset values:
  - instr_ready=0 while reset is asserted; 1 in the first IDLE cycle after release.
  - Every other output is 0.
- Latency:
  - ADD/SUB/OUT_*/illegal: accept at cycle N, strobe at N+1, instr_ready at N+2. Throughput is one instruction per 2 cycles.
  - MUL/DIV: alu_start at N+1. alu_done sampled at cycle M>N+1 gives IDLE/ready at M+1.
- instr must remain stable only in the cycle instr_valid && instr_ready. instr_valid while not ready is ignored and not latched.
- Reset mid-operation (EXEC/WAIT) aborts immediately: no retire, no illegal/timeout pulse, all strobes drop.

## Structure
- Shared package alu_seq_pkg:
  - opcode constants: OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_OUT_W, OP_OUT_R
  - ALU op_select encodings
  - state enum: IDLE, EXEC, WAIT
- Sub-module op_timer holds the WAIT cycle counter:
  - inputs: clear, enable
  - output: expired at TIMEOUT-1
  - width $clog2(TIMEOUT)

## Test plan
- Reset release, then ADD 0x03 offered: cycle+1 alu_start=1, op_select=000, sub=0; retired=1; ready returns at +2.
- SUB 0x1F, then OUT_W 0x6A: SUB gives op_select=001, sub=1. OUT_W gives out_write_enable=1, out_index=5'h0A; retired=2.
- MUL 0x40 with alu_done after 5 WAIT cycles: op_select=100 held throughout; busy=1 until done; retired increments once; no timeout.
- DIV 0x50, alu_done never asserted, TIMEOUT=8: timeout pulses exactly once; no retire; IDLE; a subsequent OUT_R 0x73 gives out_read_enable=1, out_index=3.
- Opcode 0xF0: illegal pulses once, all enables 0, retired unchanged. Reset asserted mid-WAIT: all outputs 0 at once, retired=0.
- CNT_W=2, five legal ops: retired reads 1,2,3,0,1.
